// File: rtl/fill_pkg.sv
// Shared definitions for the pill/bottle counting datapath.
package fill_pkg;

    localparam int DIGIT_W             = 4;
    localparam int DEFAULT_STARVE_MS   = 5000;
    localparam int DEFAULT_DEBOUNCE_MS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        DONE    = 2'd3
    } fill_state_t;

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up-counter; count_inc is the value the next increment would give.
module bcd_counter
    import fill_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                        clk_1khz,
    input  logic                        switch_clr,
    input  logic                        inc,
    input  logic                        clr,
    output logic [DIGITS*DIGIT_W-1:0]   count,
    output logic [DIGITS*DIGIT_W-1:0]   count_inc
);

    logic carry;
    logic at_max;

    // Ripple the +1 up through every digit that is already 9; all-nines holds.
    always_comb begin
        count_inc = count;
        carry     = 1'b1;
        at_max    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count[i*DIGIT_W +: DIGIT_W] != DIGIT_W'(9)) begin
                at_max = 1'b0;
            end
            if (carry) begin
                if (count[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(9)) begin
                    count_inc[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    count_inc[i*DIGIT_W +: DIGIT_W] = count[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
                    carry = 1'b0;
                end
            end
        end
        if (at_max) begin
            count_inc = count;
        end
    end

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/fill_counter.sv
// Hopper sensor conditioning, pill/bottle BCD counts, fill FSM and starvation watchdog.
module fill_counter
    import fill_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
    parameter int STARVE_MS   = DEFAULT_STARVE_MS,
    parameter int WD_W        = 13
) (
    input  logic         clk_1khz,
    input  logic         switch_clr,
    input  logic         hopper_level,
    input  logic         count_en,
    input  logic         bottle_ack,
    input  logic         batch_clr,
    input  logic [11:0]  target_pills,
    input  logic [7:0]   target_bottles,
    output logic [11:0]  now_pills,
    output logic [7:0]   now_bottles,
    output logic         bottle_full,
    output logic         batch_done,
    output logic         starve,
    output logic         pill_lost
);

    localparam int DB_W = $clog2(DEBOUNCE_MS) + 1;

    logic            sync_1, sync_2;
    logic            deb_level;
    logic [DB_W-1:0] deb_cnt;
    logic            pill;
    logic [WD_W-1:0] wd_cnt;

    fill_state_t state, state_nx;
    logic        pills_inc, pills_clr, bottles_inc, bottles_clr;
    logic        lost_nx, wd_run, wd_clr;
    logic [11:0] pills_next;
    logic [7:0]  bottles_next;

    // Accept a new level only after DEBOUNCE_MS consecutive differing samples.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            pill      <= 1'b0;
        end else begin
            sync_1 <= hopper_level;
            sync_2 <= sync_1;
            pill   <= 1'b0;
            if (sync_2 != deb_level) begin
                if (deb_cnt == DB_W'(DEBOUNCE_MS - 1)) begin
                    deb_level <= sync_2;
                    deb_cnt   <= '0;
                    pill      <= sync_2;
                end else begin
                    deb_cnt <= deb_cnt + DB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state     <= IDLE;
            pill_lost <= 1'b0;
        end else begin
            state     <= state_nx;
            pill_lost <= lost_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pills_inc   = 1'b0;
        pills_clr   = 1'b0;
        bottles_inc = 1'b0;
        bottles_clr = 1'b0;
        lost_nx     = 1'b0;
        wd_run      = 1'b0;
        wd_clr      = 1'b0;
        if (batch_clr) begin
            state_nx    = IDLE;
            pills_clr   = 1'b1;
            bottles_clr = 1'b1;
            wd_clr      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (count_en && target_pills != 12'h000 && target_bottles != 8'h00) begin
                        state_nx = FILLING;
                    end
                end
                FILLING: begin
                    if (count_en) begin
                        wd_run = 1'b1;
                        if (pill) begin
                            pills_inc = 1'b1;
                            if (pills_next == target_pills) begin
                                state_nx = FULL;
                            end
                        end
                    end else if (pill) begin
                        lost_nx = 1'b1;
                    end
                end
                FULL: begin
                    lost_nx = pill;
                    if (bottle_ack) begin
                        pills_clr   = 1'b1;
                        bottles_inc = 1'b1;
                        state_nx    = (bottles_next == target_bottles) ? DONE : FILLING;
                    end
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Watchdog holds at STARVE_MS-1 once starve is raised; frozen outside FILLING+count_en.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            wd_cnt <= '0;
            starve <= 1'b0;
        end else if (wd_clr) begin
            wd_cnt <= '0;
            starve <= 1'b0;
        end else if (wd_run) begin
            if (pill) begin
                wd_cnt <= '0;
                starve <= 1'b0;
            end else if (wd_cnt != WD_W'(STARVE_MS - 1)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
                if (wd_cnt == WD_W'(STARVE_MS - 2)) begin
                    starve <= 1'b1;
                end
            end
        end
    end

    bcd_counter #(.DIGITS(3)) u_pills (
        .clk_1khz  (clk_1khz),
        .switch_clr(switch_clr),
        .inc       (pills_inc),
        .clr       (pills_clr),
        .count     (now_pills),
        .count_inc (pills_next)
    );

    bcd_counter #(.DIGITS(2)) u_bottles (
        .clk_1khz  (clk_1khz),
        .switch_clr(switch_clr),
        .inc       (bottles_inc),
        .clr       (bottles_clr),
        .count     (now_bottles),
        .count_inc (bottles_next)
    );

    assign bottle_full = (state == FULL);
    assign batch_done  = (state == DONE);

endmodule
